// File: rtl/gpio_debounce.sv
// Synchronise and debounce WIDTH slide-switch inputs; per-bit clean level,
// rise/fall strobes and a write-1-to-clear sticky change flag.
module gpio_debounce #(
    parameter int WIDTH         = 16,
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 500000
) (
    input  logic             clk_i,
    input  logic             arst_n_i,
    input  logic [WIDTH-1:0] raw_i,
    input  logic [WIDTH-1:0] clr_i,
    output logic [WIDTH-1:0] db_o,
    output logic [WIDTH-1:0] rise_o,
    output logic [WIDTH-1:0] fall_o,
    output logic             chg_o,
    output logic [WIDTH-1:0] sticky_o
);

    localparam int            CW   = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] TERM = CW'(STABLE_CYCLES - 1);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync;
    logic [CW-1:0]                     r_cnt [WIDTH];
    logic [WIDTH-1:0]                  r_db;
    logic [WIDTH-1:0]                  r_rise;
    logic [WIDTH-1:0]                  r_fall;
    logic                              r_chg;
    logic [WIDTH-1:0]                  r_sticky;

    logic [WIDTH-1:0]                  w_sync;
    logic [WIDTH-1:0]                  w_upd;
    logic [CW-1:0]                     w_cnt_nxt [WIDTH];

    assign w_sync = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], raw_i};
        end
    end

    // A disagreeing sample advances the count; agreement drops any partial count.
    always_comb begin
        w_upd = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_cnt_nxt[i] = '0;
            if (w_sync[i] != r_db[i]) begin
                if (r_cnt[i] == TERM) begin
                    w_upd[i] = 1'b1;
                end else begin
                    w_cnt_nxt[i] = r_cnt[i] + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            for (int i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= '0;
            end
            r_db     <= '0;
            r_rise   <= '0;
            r_fall   <= '0;
            r_chg    <= 1'b0;
            r_sticky <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= w_cnt_nxt[i];
            end
            r_db     <= r_db ^ w_upd;
            r_rise   <= w_upd & w_sync;
            r_fall   <= w_upd & ~w_sync;
            r_chg    <= |w_upd;
            // A new strobe takes priority over a same-cycle clear.
            r_sticky <= (r_sticky & ~clr_i) | w_upd;
        end
    end

    assign db_o     = r_db;
    assign rise_o   = r_rise;
    assign fall_o   = r_fall;
    assign chg_o    = r_chg;
    assign sticky_o = r_sticky;

endmodule
